reorder_buffer: RTL and testbench

- Circular in-order reorder buffer between dispatch/CDB and the retire stage.
- Allocates one entry per dispatched instruction and captures completion data from the CDB.
- Presents the head entry to retire when it is complete, at most one retirement per cycle.
- Flushes all entries when a mispredicted branch retires, and goes permanently idle after a halt retires.

---
 rtl/reorder_buffer_if.sv | 43 ++++
 rtl/reorder_buffer.sv | 120 ++++++++++++
 tb/tb_reorder_buffer.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/reorder_buffer_if.sv
// Dispatch, completion-bus and retire signals of the reorder buffer.
// The buffer itself owns the slave side.
interface reorder_buffer_if #(
  parameter int unsigned ROB_SZ = 8,
  parameter int unsigned XLEN   = 32
);
  localparam int unsigned TAG_W = $clog2(ROB_SZ);

  logic             dp_valid;
  logic [4:0]       dp_dest_reg;
  logic             dp_halt;
  logic [TAG_W-1:0] dp_tag;
  logic             rob_full;
  logic             rob_empty;

  logic             cdb_valid;
  logic [TAG_W-1:0] cdb_tag;
  logic [XLEN-1:0]  cdb_value;
  logic             cdb_mispredict;
  logic [XLEN-1:0]  cdb_target_pc;

  logic             rt_valid;
  logic [4:0]       rt_dest_reg;
  logic [XLEN-1:0]  rt_value;
  logic             rt_halt;
  logic             rt_squash;
  logic [XLEN-1:0]  rt_target_pc;
  logic             halted;

  modport master (
    output dp_valid, dp_dest_reg, dp_halt,
    output cdb_valid, cdb_tag, cdb_value, cdb_mispredict, cdb_target_pc,
    input  dp_tag, rob_full, rob_empty,
    input  rt_valid, rt_dest_reg, rt_value, rt_halt, rt_squash, rt_target_pc, halted
  );

  modport slave (
    input  dp_valid, dp_dest_reg, dp_halt,
    input  cdb_valid, cdb_tag, cdb_value, cdb_mispredict, cdb_target_pc,
    output dp_tag, rob_full, rob_empty,
    output rt_valid, rt_dest_reg, rt_value, rt_halt, rt_squash, rt_target_pc, halted
  );
endinterface

// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer: allocates on dispatch, captures CDB results,
// retires the head in order, flushes on a mispredicted branch, and stops after halt.
module reorder_buffer #(
  parameter int unsigned ROB_SZ = 8,
  parameter int unsigned XLEN   = 32
) (
  input  logic             clock,
  input  logic             reset,
  reorder_buffer_if.slave  rob
);
  localparam int unsigned TAG_W = $clog2(ROB_SZ);
  localparam int unsigned CNT_W = $clog2(ROB_SZ) + 1;

  logic [ROB_SZ-1:0] valid_q, valid_d;
  logic [ROB_SZ-1:0] complete_q, complete_d;
  logic [ROB_SZ-1:0] mispredict_q, mispredict_d;
  logic [ROB_SZ-1:0] halt_q, halt_d;
  logic [TAG_W-1:0]  head_q, head_d;
  logic [TAG_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              halted_q, halted_d;

  logic [4:0]        dest_q   [ROB_SZ];
  logic [XLEN-1:0]   value_q  [ROB_SZ];
  logic [XLEN-1:0]   tpc_q    [ROB_SZ];

  logic retire_c, squash_c, full_c, accept_c, cdb_wr_c;

  // Retire is decided purely from the registered head entry.
  always_comb begin
    retire_c = valid_q[head_q] & complete_q[head_q] & ~halted_q;
    squash_c = retire_c & mispredict_q[head_q];
    full_c   = (count_q == CNT_W'(ROB_SZ));
    accept_c = rob.dp_valid & ~full_c & ~halted_q & ~squash_c;
    cdb_wr_c = rob.cdb_valid & valid_q[rob.cdb_tag] & ~squash_c;
  end

  always_comb begin
    valid_d      = valid_q;
    complete_d   = complete_q;
    mispredict_d = mispredict_q;
    halt_d       = halt_q;
    head_d       = head_q;
    tail_d       = tail_q;
    count_d      = count_q;
    halted_d     = halted_q;

    if (cdb_wr_c) begin
      complete_d[rob.cdb_tag]   = 1'b1;
      mispredict_d[rob.cdb_tag] = rob.cdb_mispredict;
    end
    if (retire_c) begin
      valid_d[head_q] = 1'b0;
      head_d          = TAG_W'(head_q + TAG_W'(1));
      if (halt_q[head_q]) halted_d = 1'b1;
    end
    if (accept_c) begin
      valid_d[tail_q]      = 1'b1;
      complete_d[tail_q]   = 1'b0;
      mispredict_d[tail_q] = 1'b0;
      halt_d[tail_q]       = rob.dp_halt;
      tail_d               = TAG_W'(tail_q + TAG_W'(1));
    end
    count_d = CNT_W'(count_q + CNT_W'(accept_c) - CNT_W'(retire_c));

    // A retiring mispredict discards everything younger, including this cycle's events.
    if (squash_c) begin
      valid_d      = '0;
      complete_d   = '0;
      mispredict_d = '0;
      head_d       = '0;
      tail_d       = '0;
      count_d      = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q      <= '0;
      complete_q   <= '0;
      mispredict_q <= '0;
      halt_q       <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      halted_q     <= 1'b0;
    end else begin
      valid_q      <= valid_d;
      complete_q   <= complete_d;
      mispredict_q <= mispredict_d;
      halt_q       <= halt_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      halted_q     <= halted_d;
    end
  end

  // Payload storage needs no reset; it is only observed behind valid/complete.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (accept_c) dest_q[tail_q] <= rob.dp_dest_reg;
      if (cdb_wr_c) begin
        value_q[rob.cdb_tag] <= rob.cdb_value;
        tpc_q[rob.cdb_tag]   <= rob.cdb_target_pc;
      end
    end
  end

  assign rob.dp_tag       = tail_q;
  assign rob.rob_full     = full_c;
  assign rob.rob_empty    = (count_q == '0);
  assign rob.rt_valid     = retire_c;
  assign rob.rt_dest_reg  = retire_c ? dest_q[head_q] : '0;
  assign rob.rt_value     = retire_c ? value_q[head_q] : '0;
  assign rob.rt_halt      = retire_c & halt_q[head_q];
  assign rob.rt_squash    = squash_c;
  assign rob.rt_target_pc = retire_c ? tpc_q[head_q] : '0;
  assign rob.halted       = halted_q;
endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: directed scenarios plus random traffic,
// compared every cycle against a queue-based model of in-order retirement.
module tb_reorder_buffer;
  localparam int ROB_SZ = 8;
  localparam int XLEN   = 32;
  localparam int TAG_W  = 3;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  reorder_buffer_if #(.ROB_SZ(ROB_SZ), .XLEN(XLEN)) bus ();
  reorder_buffer #(.ROB_SZ(ROB_SZ), .XLEN(XLEN)) dut (.clock(clock), .reset(reset), .rob(bus));

  always #5 clock = ~clock;

  typedef struct {
    logic [4:0]  dest;
    bit          halt;
    bit          comp;
    logic [31:0] val;
    bit          mis;
    logic [31:0] tpc;
  } ent_t;

  ent_t mq[$];
  int   m_head = 0;
  bit   m_halted = 1'b0;

  function automatic int m_tail();
    return (m_head + mq.size()) % ROB_SZ;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit dv, input logic [4:0] dd, input bit dh,
                       input bit cv, input int ct, input logic [31:0] cval,
                       input bit cm, input logic [31:0] ctpc);
    bus.dp_valid       = dv;
    bus.dp_dest_reg    = dd;
    bus.dp_halt        = dh;
    bus.cdb_valid      = cv;
    bus.cdb_tag        = TAG_W'(ct);
    bus.cdb_value      = cval;
    bus.cdb_mispredict = cm;
    bus.cdb_target_pc  = ctpc;
  endtask

  task automatic idle();
    drive(0, 5'd0, 0, 0, 0, 32'h0, 0, 32'h0);
  endtask

  // One clock: check outputs mid-cycle against the model, then advance the model.
  task automatic cycle();
    bit ret, sq, acc, full;
    int idx;
    ent_t e;
    @(negedge clock);
    full = (mq.size() == ROB_SZ);
    ret  = (mq.size() > 0) && mq[0].comp && !m_halted;
    sq   = ret && mq[0].mis;
    acc  = bus.dp_valid && !full && !m_halted && !sq;
    chk("dp_tag",       32'(bus.dp_tag),       32'(m_tail()));
    chk("rob_full",     32'(bus.rob_full),     32'(full));
    chk("rob_empty",    32'(bus.rob_empty),    32'(mq.size() == 0));
    chk("rt_valid",     32'(bus.rt_valid),     32'(ret));
    chk("rt_dest_reg",  32'(bus.rt_dest_reg),  ret ? 32'(mq[0].dest) : 32'h0);
    chk("rt_value",     bus.rt_value,          ret ? mq[0].val : 32'h0);
    chk("rt_halt",      32'(bus.rt_halt),      32'(ret && mq[0].halt));
    chk("rt_squash",    32'(bus.rt_squash),    32'(sq));
    chk("rt_target_pc", bus.rt_target_pc,      ret ? mq[0].tpc : 32'h0);
    chk("halted",       32'(bus.halted),       32'(m_halted));
    @(posedge clock);
    if (reset) begin
      mq.delete();
      m_head   = 0;
      m_halted = 1'b0;
    end else begin
      if (ret && mq[0].halt) m_halted = 1'b1;
      if (sq) begin
        mq.delete();
        m_head = 0;
      end else begin
        if (bus.cdb_valid) begin
          idx = (int'(bus.cdb_tag) - m_head + ROB_SZ) % ROB_SZ;
          if (idx < mq.size()) begin
            e      = mq[idx];
            e.comp = 1'b1;
            e.val  = bus.cdb_value;
            e.mis  = bus.cdb_mispredict;
            e.tpc  = bus.cdb_target_pc;
            mq[idx] = e;
          end
        end
        if (ret) begin
          void'(mq.pop_front());
          m_head = (m_head + 1) % ROB_SZ;
        end
        if (acc) begin
          e = '{dest: bus.dp_dest_reg, halt: bus.dp_halt, comp: 1'b0,
                val: 32'h0, mis: 1'b0, tpc: 32'h0};
          mq.push_back(e);
        end
      end
    end
    #1;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
  endtask

  initial begin
    int last;
    idle();
    reset = 1'b1;
    @(posedge clock);
    #1;
    do_reset();

    // Fill: dest 1..8, then a refused ninth dispatch.
    for (int i = 0; i < 8; i++) begin
      drive(1, 5'(i + 1), 0, 0, 0, 32'h0, 0, 32'h0);
      cycle();
    end
    chk("full_after_8", 32'(bus.rob_full), 32'h1);
    drive(1, 5'd9, 0, 0, 0, 32'h0, 0, 32'h0);
    cycle();
    chk("tail_after_refused", 32'(bus.dp_tag), 32'h0);

    // Out-of-order completion, in-order retirement.
    drive(0, 5'd0, 0, 1, 2, 32'hA, 0, 32'h0); cycle();
    drive(0, 5'd0, 0, 1, 1, 32'hB, 0, 32'h0); cycle();
    drive(0, 5'd0, 0, 1, 0, 32'hC, 0, 32'h0); cycle();
    idle();
    chk("first_retire_valid", 32'(bus.rt_valid), 32'h1);
    chk("first_retire_value", bus.rt_value, 32'hC);
    for (int i = 0; i < 4; i++) cycle();

    // Full with a complete head: retire proceeds, dispatch refused that cycle.
    for (int i = 0; i < 3; i++) begin
      drive(1, 5'(20 + i), 0, 0, 0, 32'h0, 0, 32'h0);
      cycle();
    end
    drive(0, 5'd0, 0, 1, 3, 32'h33, 0, 32'h0); cycle();
    drive(1, 5'd25, 0, 0, 0, 32'h0, 0, 32'h0); cycle();
    chk("refill_tag", 32'(bus.dp_tag), 32'h3);
    cycle();
    chk("refill_full", 32'(bus.rob_full), 32'h1);

    // Mispredict at tag 3 with a same-cycle dispatch.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1, 5'(i + 1), 0, 0, 0, 32'h0, 0, 32'h0);
      cycle();
    end
    drive(0, 5'd0, 0, 1, 0, 32'h10, 0, 32'h0);   cycle();
    drive(0, 5'd0, 0, 1, 1, 32'h11, 0, 32'h0);   cycle();
    drive(0, 5'd0, 0, 1, 2, 32'h12, 0, 32'h0);   cycle();
    drive(0, 5'd0, 0, 1, 3, 32'h13, 1, 32'h100); cycle();
    drive(1, 5'd30, 0, 0, 0, 32'h0, 0, 32'h0);
    chk("squash_flag", 32'(bus.rt_squash), 32'h1);
    chk("squash_pc", bus.rt_target_pc, 32'h100);
    cycle();
    idle();
    chk("post_squash_empty", 32'(bus.rob_empty), 32'h1);
    chk("post_squash_tag", 32'(bus.dp_tag), 32'h0);
    cycle();

    // Halt behind tag 0; later entries never retire.
    do_reset();
    drive(1, 5'd5, 0, 0, 0, 32'h0, 0, 32'h0); cycle();
    drive(1, 5'd6, 1, 0, 0, 32'h0, 0, 32'h0); cycle();
    drive(1, 5'd7, 0, 0, 0, 32'h0, 0, 32'h0); cycle();
    drive(0, 5'd0, 0, 1, 0, 32'h50, 0, 32'h0); cycle();
    drive(0, 5'd0, 0, 1, 1, 32'h51, 0, 32'h0); cycle();
    drive(0, 5'd0, 0, 1, 2, 32'h52, 0, 32'h0);
    chk("halt_retire", 32'(bus.rt_halt), 32'h1);
    cycle();
    idle();
    for (int i = 0; i < 4; i++) begin
      drive(1, 5'd8, 0, 0, 0, 32'h0, 0, 32'h0);
      cycle();
    end
    chk("halted_sticky", 32'(bus.halted), 32'h1);

    // Steady dispatch/retire pairs wrapping the pointers, then a stray CDB.
    do_reset();
    last = 0;
    for (int i = 0; i < 21; i++) begin
      drive(1, 5'(i), 0, (i > 0), last, 32'(i * 3), 0, 32'h0);
      last = m_tail();
      cycle();
    end
    drive(0, 5'd0, 0, 1, (m_tail() + 3) % ROB_SZ, 32'hDEAD, 1, 32'hBEEF);
    cycle();
    idle();
    for (int i = 0; i < 4; i++) cycle();

    // Random traffic with occasional resets, mispredicts and halts.
    do_reset();
    for (int i = 0; i < 500; i++) begin
      int tag;
      if (mq.size() > 0 && ($urandom % 4) != 0)
        tag = (m_head + int'($urandom % mq.size())) % ROB_SZ;
      else
        tag = int'($urandom % ROB_SZ);
      drive(($urandom % 3) != 0, 5'($urandom), ($urandom % 25) == 0,
            ($urandom % 2) == 0, tag, $urandom, ($urandom % 12) == 0, $urandom);
      reset = (($urandom % 70) == 0);
      cycle();
    end
    reset = 1'b0;
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
